// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 Hz segment lengths for the VGA raster.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } axis_state_t;

    localparam int POS_W = 10;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    function automatic int seg_len(axis_state_t st, int vis, int fr, int sy, int bk);
        case (st)
            VISIBLE: return vis;
            FRONT:   return fr;
            SYNC:    return sy;
            default: return bk;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the generator to the sprite/palette renderers.
interface vga_timing_gen_if #(
    parameter int FCNT_W = 16
);
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic              hs;
    logic              vs;
    logic              line_start;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus VISIBLE/FRONT/SYNC/BACK segment FSM.
// pos/state are the values that take effect at the next clock edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int VIS_LEN   = DEF_H_VISIBLE,
    parameter int FRONT_LEN = DEF_H_FRONT,
    parameter int SYNC_LEN  = DEF_H_SYNC,
    parameter int BACK_LEN  = DEF_H_BACK
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic             advance,
    output logic [POS_W-1:0] pos,
    output axis_state_t      state,
    output logic             wrap
);
    localparam int TOTAL = VIS_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

    // Absolute position of the last pixel/line in each segment.
    localparam logic [POS_W-1:0] END_VIS   =
        POS_W'(seg_len(VISIBLE, VIS_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN) - 1);
    localparam logic [POS_W-1:0] END_FRONT =
        POS_W'(VIS_LEN + seg_len(FRONT, VIS_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN) - 1);
    localparam logic [POS_W-1:0] END_SYNC  =
        POS_W'(VIS_LEN + FRONT_LEN + seg_len(SYNC, VIS_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN) - 1);
    localparam logic [POS_W-1:0] END_BACK  = POS_W'(TOTAL - 1);

    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] seg_end;
    axis_state_t      state_q;

    always_comb begin
        seg_end = END_BACK;
        case (state_q)
            VISIBLE: seg_end = END_VIS;
            FRONT:   seg_end = END_FRONT;
            SYNC:    seg_end = END_SYNC;
            default: seg_end = END_BACK;
        endcase
    end

    always_comb begin
        pos   = pos_q;
        state = state_q;
        wrap  = 1'b0;
        if (advance) begin
            if (pos_q == END_BACK) begin
                pos  = '0;
                wrap = 1'b1;
            end else begin
                pos = pos_q + POS_W'(1);
            end
            if (pos_q == seg_end) begin
                case (state_q)
                    VISIBLE: state = FRONT;
                    FRONT:   state = SYNC;
                    SYNC:    state = BACK;
                    default: state = VISIBLE;
                endcase
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            pos_q   <= '0;
            state_q <= VISIBLE;
        end else begin
            pos_q   <= pos;
            state_q <= state;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: two chained axis counters and a registered output decode,
// so DrawX/DrawY, blank, syncs and pulses always describe the same pixel.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter int FCNT_W    = 16
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    vga_timing_gen_if.master  vid
);
    logic [POS_W-1:0] h_pos, v_pos;
    axis_state_t      h_state, v_state;
    logic             h_wrap, v_wrap;

    vga_axis_counter #(
        .VIS_LEN(H_VISIBLE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
    ) u_h (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .advance (1'b1),
        .pos     (h_pos),
        .state   (h_state),
        .wrap    (h_wrap)
    );

    // V only steps on the line wrap, so its wrap implies a full frame wrap.
    vga_axis_counter #(
        .VIS_LEN(V_VISIBLE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
    ) u_v (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .advance (h_wrap),
        .pos     (v_pos),
        .state   (v_state),
        .wrap    (v_wrap)
    );

    logic [POS_W-1:0]  draw_x_q, draw_y_q;
    logic              blank_q, hs_q, vs_q, line_start_q, frame_start_q;
    logic [FCNT_W-1:0] fcnt_q;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            draw_x_q      <= '0;
            draw_y_q      <= '0;
            blank_q       <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            fcnt_q        <= '0;
        end else begin
            draw_x_q      <= h_pos;
            draw_y_q      <= v_pos;
            blank_q       <= (h_state == VISIBLE) && (v_state == VISIBLE);
            hs_q          <= (h_state != SYNC);
            vs_q          <= (v_state != SYNC);
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
            if (v_wrap)
                fcnt_q <= fcnt_q + FCNT_W'(1);
        end
    end

    assign vid.DrawX       = draw_x_q;
    assign vid.DrawY       = draw_y_q;
    assign vid.blank       = blank_q;
    assign vid.hs          = hs_q;
    assign vid.vs          = vs_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_count = fcnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size raster for line-level checks, a shrunken raster for frame-level
// checks, both compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    // Shrunken geometry: 25 x 19 raster, 3-bit frame counter.
    localparam int SH_V = 16, SH_F = 2, SH_S = 4, SH_B = 3;
    localparam int SV_V = 12, SV_F = 2, SV_S = 2, SV_B = 3;
    localparam int S_FW = 3;
    localparam int S_HT = SH_V + SH_F + SH_S + SH_B;
    localparam int S_TOT = S_HT * (SV_V + SV_F + SV_S + SV_B);

    logic clk = 1'b0;
    logic rst_f = 1'b0;
    logic rst_s = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.FCNT_W(16))   vid_f ();
    vga_timing_gen_if #(.FCNT_W(S_FW)) vid_s ();

    vga_timing_gen dut_f (
        .vga_clk (clk),
        .reset_n (rst_f),
        .vid     (vid_f)
    );

    vga_timing_gen #(
        .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
        .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B),
        .FCNT_W(S_FW)
    ) dut_s (
        .vga_clk (clk),
        .reset_n (rst_s),
        .vid     (vid_s)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int x, y, blank, hs, vs, ls, fs, fc;
    } vid_t;

    // Raster state after k clock edges since reset release (k = 0: reset values).
    function automatic vid_t model(int k, int hv, int hf, int hsl, int hb,
                                   int vv, int vf, int vsl, int vb, int fw);
        vid_t r;
        int ht, vt, n;
        ht = hv + hf + hsl + hb;
        vt = vv + vf + vsl + vb;
        if (k == 0) begin
            r.x = 0; r.y = 0; r.blank = 0; r.hs = 1; r.vs = 1;
            r.ls = 0; r.fs = 0; r.fc = 0;
            return r;
        end
        n       = k % (ht * vt);
        r.x     = n % ht;
        r.y     = n / ht;
        r.blank = (r.x < hv && r.y < vv) ? 1 : 0;
        r.hs    = (r.x >= hv + hf && r.x < hv + hf + hsl) ? 0 : 1;
        r.vs    = (r.y >= vv + vf && r.y < vv + vf + vsl) ? 0 : 1;
        r.ls    = (r.x == 0) ? 1 : 0;
        r.fs    = (r.x == 0 && r.y == 0) ? 1 : 0;
        r.fc    = (k / (ht * vt)) % (1 << fw);
        return r;
    endfunction

    function automatic vid_t model_f(int k);
        return model(k, 640, 16, 96, 48, 480, 10, 2, 33, 16);
    endfunction

    function automatic vid_t model_s(int k);
        return model(k, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, S_FW);
    endfunction

    function automatic vid_t obs_f();
        vid_t r;
        r.x = int'(vid_f.DrawX); r.y = int'(vid_f.DrawY);
        r.blank = int'(vid_f.blank); r.hs = int'(vid_f.hs); r.vs = int'(vid_f.vs);
        r.ls = int'(vid_f.line_start); r.fs = int'(vid_f.frame_start);
        r.fc = int'(vid_f.frame_count);
        return r;
    endfunction

    function automatic vid_t obs_s();
        vid_t r;
        r.x = int'(vid_s.DrawX); r.y = int'(vid_s.DrawY);
        r.blank = int'(vid_s.blank); r.hs = int'(vid_s.hs); r.vs = int'(vid_s.vs);
        r.ls = int'(vid_s.line_start); r.fs = int'(vid_s.frame_start);
        r.fc = int'(vid_s.frame_count);
        return r;
    endfunction

    task automatic cmp(input string p, input vid_t o, input vid_t e);
        chk({p, ".DrawX"},       o.x,     e.x);
        chk({p, ".DrawY"},       o.y,     e.y);
        chk({p, ".blank"},       o.blank, e.blank);
        chk({p, ".hs"},          o.hs,    e.hs);
        chk({p, ".vs"},          o.vs,    e.vs);
        chk({p, ".line_start"},  o.ls,    e.ls);
        chk({p, ".frame_start"}, o.fs,    e.fs);
        chk({p, ".frame_count"}, o.fc,    e.fc);
    endtask

    int kf = 0, ks = 0;
    int hs_lo = 0, bl_hi = 0, ls_cnt = 0;
    int vs_lo = 0, fs_cnt = 0, bl_vbad = 0;

    task automatic run_f(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            kf++;
            @(negedge clk);
            cmp("full", obs_f(), model_f(kf));
            if (kf <= 800) begin
                hs_lo += (vid_f.hs == 1'b0) ? 1 : 0;
                bl_hi += (vid_f.blank == 1'b1) ? 1 : 0;
            end
            if (kf <= 8800)
                ls_cnt += (vid_f.line_start == 1'b1) ? 1 : 0;
            if (kf == 8800) begin
                chk("line_wrap.DrawX", int'(vid_f.DrawX), 0);
                chk("line_wrap.DrawY", int'(vid_f.DrawY), 11);
                chk("line_wrap.blank", int'(vid_f.blank), 1);
            end
        end
    endtask

    task automatic run_s(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            ks++;
            @(negedge clk);
            cmp("small", obs_s(), model_s(ks));
            if (ks <= S_TOT)
                vs_lo += (vid_s.vs == 1'b0) ? 1 : 0;
            if (ks <= 8 * S_TOT)
                fs_cnt += (vid_s.frame_start == 1'b1) ? 1 : 0;
            if (int'(vid_s.DrawY) >= SV_V && vid_s.blank == 1'b1)
                bl_vbad++;
            if (ks == S_TOT)
                chk("frame_wrap.count1", int'(vid_s.frame_count), 1);
            if (ks == 8 * S_TOT - 1)
                chk("frame_wrap.count_max", int'(vid_s.frame_count), 7);
            if (ks == 8 * S_TOT)
                chk("frame_wrap.count_rollover", int'(vid_s.frame_count), 0);
        end
    endtask

    initial begin
        int tgt, hold;

        // Full-size raster: reset, line boundaries, line wrap.
        repeat (5) @(posedge clk);
        @(negedge clk);
        cmp("full_rst", obs_f(), model_f(0));
        cmp("small_rst", obs_s(), model_s(0));
        rst_f = 1'b1;
        kf = 0;
        cmp("full_rel", obs_f(), model_f(0));
        run_f(8800 + int'($urandom_range(0, 400)));
        chk("hs_low_cycles", hs_lo, 96);
        chk("blank_cycles_line0", bl_hi, 640);
        chk("line_start_count", ls_cnt, 11);

        // Asynchronous reset at DrawX = 700 (inside hsync).
        tgt = 700;
        while (kf % 800 != tgt) run_f(1);
        chk("pre_rst.hs", int'(vid_f.hs), 0);
        #($urandom_range(1, 3));
        rst_f = 1'b0;
        #1;
        cmp("full_async", obs_f(), model_f(0));
        hold = int'($urandom_range(1, 4));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmp("full_hold", obs_f(), model_f(0));
        end
        rst_f = 1'b1;
        kf = 0;
        run_f(2000);

        // Shrunken raster: vertical boundaries, frame wrap, counter rollover.
        @(negedge clk);
        rst_s = 1'b1;
        ks = 0;
        cmp("small_rel", obs_s(), model_s(0));
        run_s(9 * S_TOT + int'($urandom_range(0, 200)));
        chk("vs_low_cycles", vs_lo, 2 * S_HT);
        chk("frame_start_count", fs_cnt, 8);
        chk("blank_below_visible", bl_vbad, 0);

        // Asynchronous reset with hs and vs both low.
        tgt = (SV_V + SV_F + 1) * S_HT + (SH_V + SH_F + 1);
        while (ks % S_TOT != tgt) run_s(1);
        chk("pre_rst.hs_vs", int'({vid_s.hs, vid_s.vs}), 0);
        #($urandom_range(1, 3));
        rst_s = 1'b0;
        #1;
        cmp("small_async", obs_s(), model_s(0));
        hold = int'($urandom_range(1, 4));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmp("small_hold", obs_s(), model_s(0));
        end
        rst_s = 1'b1;
        ks = 0;
        run_s(S_TOT + 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
